// File: rtl/prbs_frame_checker.sv
// Serial PRBS frame checker: header hunt, LFSR self-seed, bit compare and error/lock accounting.
// Latency: header_found/err_pulse one cycle after the sampled bit, counters one cycle later; no backpressure (bit per clk).
module prbs_frame_checker #(
    parameter int INV_PATTERN = 0,
    parameter int POLY_LENGHT = 7,
    parameter int POLY_TAP    = 5,
    parameter int CNT_WIDTH   = 32,
    parameter int LOSS_WINDOW = 64,
    parameter int LOSS_THRESH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 check_enable,
    input  logic                 clear_counters,
    input  logic                 data_in,
    output logic                 header_found,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [CNT_WIDTH-1:0] bit_count,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam logic [9:0] HEADER = 10'b1100110011;
    localparam int FILL_W = $clog2(POLY_LENGHT + 1);
    localparam int WIN_W  = $clog2(LOSS_WINDOW + 1);
    localparam int ERR_W  = $clog2(LOSS_THRESH + 1);
    localparam logic INV  = (INV_PATTERN != 0);

    typedef enum logic [1:0] {IDLE, HUNT, FILL, CHECK} state_t;

    state_t                 state;
    logic [8:0]             hdr_sr;
    logic [POLY_LENGHT-1:0] lfsr;
    logic [FILL_W-1:0]      fill_cnt;
    logic [WIN_W-1:0]       win_cnt;
    logic [ERR_W-1:0]       win_err;
    logic                   chk_vld;

    logic             expected;
    logic             mismatch;
    logic             hdr_match;
    logic [ERR_W-1:0] win_err_inc;

    assign expected    = lfsr[POLY_LENGHT-1] ^ lfsr[POLY_TAP-1] ^ INV;
    assign mismatch    = data_in ^ expected;
    assign hdr_match   = ({hdr_sr, data_in} == HEADER);
    assign win_err_inc = win_err + ERR_W'(mismatch);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            hdr_sr         <= '0;
            lfsr           <= '0;
            fill_cnt       <= '0;
            win_cnt        <= '0;
            win_err        <= '0;
            chk_vld        <= 1'b0;
            header_found   <= 1'b0;
            locked         <= 1'b0;
            err_pulse      <= 1'b0;
            bit_count      <= '0;
            err_count      <= '0;
        end else begin
            header_found <= 1'b0;
            chk_vld      <= 1'b0;
            err_pulse    <= 1'b0;

            // Counters trail the compare by one stage; a clear drops that stage's increment.
            if (clear_counters) begin
                bit_count <= '0;
                err_count <= '0;
            end else begin
                if (chk_vld && bit_count != '1)
                    bit_count <= bit_count + CNT_WIDTH'(1);
                if (err_pulse && err_count != '1)
                    err_count <= err_count + CNT_WIDTH'(1);
            end

            if (!check_enable) begin
                state    <= IDLE;
                locked   <= 1'b0;
                hdr_sr   <= '0;
                fill_cnt <= '0;
                win_cnt  <= '0;
                win_err  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state  <= HUNT;
                        hdr_sr <= '0;
                    end
                    HUNT: begin
                        hdr_sr <= {hdr_sr[7:0], data_in};
                        if (hdr_match) begin
                            state        <= FILL;
                            header_found <= 1'b1;
                            fill_cnt     <= '0;
                        end
                    end
                    FILL: begin
                        lfsr     <= {lfsr[POLY_LENGHT-2:0], data_in};
                        fill_cnt <= fill_cnt + FILL_W'(1);
                        if (fill_cnt == FILL_W'(POLY_LENGHT - 1)) begin
                            state   <= CHECK;
                            locked  <= 1'b1;
                            win_cnt <= '0;
                            win_err <= '0;
                        end
                    end
                    CHECK: begin
                        // Feeding back the prediction keeps one flipped bit from corrupting later predictions.
                        lfsr      <= {lfsr[POLY_LENGHT-2:0], expected};
                        chk_vld   <= 1'b1;
                        err_pulse <= mismatch;
                        if (win_err_inc >= ERR_W'(LOSS_THRESH)) begin
                            state   <= HUNT;
                            locked  <= 1'b0;
                            hdr_sr  <= '0;
                            win_cnt <= '0;
                            win_err <= '0;
                        end else if (win_cnt == WIN_W'(LOSS_WINDOW - 1)) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + WIN_W'(1);
                            win_err <= win_err_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prbs_frame_checker.sv
// Bench for prbs_frame_checker: stream built from the x^7+x^5+1 recurrence, table rows, random frames, corner sequences.
module tb_prbs_frame_checker;

    localparam logic [9:0] HDR = 10'b1100110011;

    logic        clk = 1'b0;
    logic        rst, check_enable, clear_counters, data_in;
    logic        header_found, locked, err_pulse;
    logic [31:0] bit_count, err_count;
    logic        s_header_found, s_locked, s_err_pulse;
    logic [3:0]  s_bit_count, s_err_count;

    int         errors = 0;
    int         checks = 0;
    int         hf_cnt, ep_cnt, ep_bad;
    logic [9:0] sent_sr;
    bit         seq[$];
    int         flip_q[$];

    typedef struct {
        string      nm;
        logic [9:0] hdr;
        int         n;
        int         f_start;
        int         f_len;
        int         f_step;
        logic       exp_found;
        logic       exp_locked;
        int         exp_bits;
        int         exp_errs;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;

    prbs_frame_checker dut (
        .clk(clk), .rst(rst), .check_enable(check_enable), .clear_counters(clear_counters),
        .data_in(data_in), .header_found(header_found), .locked(locked), .err_pulse(err_pulse),
        .bit_count(bit_count), .err_count(err_count)
    );

    prbs_frame_checker #(.CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .check_enable(check_enable), .clear_counters(clear_counters),
        .data_in(data_in), .header_found(s_header_found), .locked(s_locked), .err_pulse(s_err_pulse),
        .bit_count(s_bit_count), .err_count(s_err_count)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int min15(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    function automatic bit is_flip(input int j);
        foreach (flip_q[k]) if (flip_q[k] == j) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input logic d);
        data_in = d;
        @(posedge clk);
        @(negedge clk);
        sent_sr = {sent_sr[8:0], d};
        hf_cnt += int'(header_found);
        ep_cnt += int'(err_pulse);
    endtask

    task automatic rnd_step();
        logic b;
        b = 1'($urandom_range(0, 1));
        if ({sent_sr[8:0], b} == HDR) b = ~b;
        step(b);
    endtask

    task automatic do_reset();
        rst = 1'b0; check_enable = 1'b0; clear_counters = 1'b0; data_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sent_sr = '0;
    endtask

    task automatic send_hdr(input logic [9:0] h);
        for (int i = 0; i < 10; i++) step(h[9-i]);
    endtask

    // Generator stream: first 7 bits are the seed, then s[i] = s[i-7] ^ s[i-5].
    task automatic build_seq(input logic [6:0] seed, input int n);
        seq.delete();
        for (int i = 0; i < 7; i++) seq.push_back(seed[6-i]);
        for (int i = 7; i < n + 8; i++) seq.push_back(seq[i-7] ^ seq[i-5]);
    endtask

    task automatic send_fill(input string nm);
        for (int i = 0; i < 7; i++) begin
            step(seq[i]);
            if (i == 5) check({nm, " unlocked_after_6_fill"}, 64'(locked), 64'(0));
        end
        check({nm, " locked_after_7_fill"}, 64'(locked), 64'(1));
    endtask

    // n checked bits (flip_q applied) plus one clean trailing bit so the counters settle.
    task automatic send_check(input int n);
        bit f;
        for (int j = 0; j < n; j++) begin
            f = is_flip(j);
            step(seq[7+j] ^ f);
            if (f && err_pulse !== 1'b1) ep_bad++;
        end
        step(seq[7+n]);
    endtask

    task automatic run_frame(input vec_t v, input logic [6:0] seed, input int pre);
        do_reset();
        check_enable = 1'b1;
        hf_cnt = 0; ep_cnt = 0; ep_bad = 0;
        repeat (pre) step(1'b0);
        send_hdr(v.hdr);
        check({v.nm, " header_found_timing"}, 64'(header_found), 64'(v.exp_found));
        if (v.exp_found) begin
            build_seq(seed, v.n);
            send_fill(v.nm);
            send_check(v.n);
        end else begin
            repeat (v.n + 1) rnd_step();
        end
        check({v.nm, " locked"}, 64'(locked), 64'(v.exp_locked));
        check({v.nm, " bit_count"}, 64'(bit_count), 64'(v.exp_bits));
        check({v.nm, " err_count"}, 64'(err_count), 64'(v.exp_errs));
        check({v.nm, " header_pulses"}, 64'(hf_cnt), 64'(v.exp_found));
        check({v.nm, " err_pulses"}, 64'(ep_cnt), 64'(v.exp_errs));
        check({v.nm, " err_pulse_align"}, 64'(ep_bad), 64'(0));
        check({v.nm, " sat_bit_count"}, 64'(s_bit_count), 64'(min15(v.exp_bits)));
        check({v.nm, " sat_err_count"}, 64'(s_err_count), 64'(min15(v.exp_errs)));
    endtask

    task automatic load_flips(input vec_t v);
        flip_q.delete();
        for (int k = 0; k < v.f_len; k++) flip_q.push_back(v.f_start + k * v.f_step);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   k, p;
        rst = 1'b0; check_enable = 1'b0; clear_counters = 1'b0; data_in = 1'b0;
        hf_cnt = 0; ep_cnt = 0; ep_bad = 0; sent_sr = '0;

        tbl[0] = '{"lock_1000",    HDR,           1000, 0,   0, 1, 1'b1, 1'b1, 1000, 0};
        tbl[1] = '{"single_flip",  HDR,           300,  200, 1, 1, 1'b1, 1'b1, 300,  1};
        tbl[2] = '{"bad_header",   10'b1100110001, 300, 0,   0, 1, 1'b0, 1'b0, 0,    0};
        tbl[3] = '{"loss_8_errs",  HDR,           108,  100, 8, 1, 1'b1, 1'b0, 108,  8};
        tbl[4] = '{"seven_errs",   HDR,           100,  10,  7, 2, 1'b1, 1'b1, 100,  7};
        tbl[5] = '{"split_window", HDR,           100,  60,  8, 1, 1'b1, 1'b1, 100,  8};

        do_reset();
        check("reset header_found", 64'(header_found), 64'(0));
        check("reset locked", 64'(locked), 64'(0));
        check("reset err_pulse", 64'(err_pulse), 64'(0));
        check("reset bit_count", 64'(bit_count), 64'(0));
        check("reset err_count", 64'(err_count), 64'(0));

        for (int i = 0; i < 6; i++) begin
            load_flips(tbl[i]);
            run_frame(tbl[i], 7'b1010011, 3);
        end

        for (int r = 0; r < 5; r++) begin
            v.nm = "random"; v.hdr = HDR;
            v.n = int'($urandom_range(60, 400));
            v.f_start = 0; v.f_len = 0; v.f_step = 1;
            flip_q.delete();
            k = int'($urandom_range(0, 3));
            while (flip_q.size() < k) begin
                p = int'($urandom_range(0, v.n - 1));
                if (!is_flip(p)) flip_q.push_back(p);
            end
            v.exp_found = 1'b1; v.exp_locked = 1'b1; v.exp_bits = v.n; v.exp_errs = k;
            run_frame(v, 7'($urandom_range(1, 127)), int'($urandom_range(2, 20)));
        end

        // Loss of lock, then a fresh header relocks while counts carry on.
        load_flips(tbl[3]);
        run_frame(tbl[3], 7'b0111001, 4);
        flip_q.delete();
        hf_cnt = 0;
        repeat (3) step(1'b0);
        send_hdr(HDR);
        check("relock header_found", 64'(header_found), 64'(1));
        build_seq(7'b1100101, 40);
        send_fill("relock");
        send_check(40);
        check("relock locked", 64'(locked), 64'(1));
        check("relock bit_count", 64'(bit_count), 64'(148));
        check("relock err_count", 64'(err_count), 64'(8));
        check_enable = 1'b0;
        step(1'b0);
        check("disable locked", 64'(locked), 64'(0));
        check("disable bit_count", 64'(bit_count), 64'(149));
        step(1'b0);
        check("disable bit_count held", 64'(bit_count), 64'(149));

        // Clear on the same cycle the mismatch is reported; its increment is dropped.
        do_reset();
        check_enable = 1'b1;
        repeat (3) step(1'b0);
        send_hdr(HDR);
        build_seq(7'b0000001, 50);
        send_fill("clear");
        for (int j = 0; j < 50; j++) begin
            clear_counters = (j == 31);
            step(seq[7+j] ^ bit'(j == 30));
            if (j == 30) check("clear err_pulse", 64'(err_pulse), 64'(1));
            if (j == 31) begin
                check("clear bit_count zero", 64'(bit_count), 64'(0));
                check("clear err_count zero", 64'(err_count), 64'(0));
            end
        end
        clear_counters = 1'b0;
        step(seq[57]);
        check("clear bit_count resumed", 64'(bit_count), 64'(19));
        check("clear err_count resumed", 64'(err_count), 64'(0));

        // Reset pulse while locked; relock needs a new header.
        flip_q.delete();
        do_reset();
        check_enable = 1'b1;
        repeat (3) step(1'b0);
        send_hdr(HDR);
        build_seq(7'b1011100, 50);
        send_fill("midrst");
        send_check(50);
        rst = 1'b0;
        step(1'b0);
        rst = 1'b1;
        check("midrst header_found", 64'(header_found), 64'(0));
        check("midrst locked", 64'(locked), 64'(0));
        check("midrst err_pulse", 64'(err_pulse), 64'(0));
        check("midrst bit_count", 64'(bit_count), 64'(0));
        check("midrst err_count", 64'(err_count), 64'(0));
        hf_cnt = 0;
        repeat (60) rnd_step();
        check("midrst no_header locked", 64'(locked), 64'(0));
        check("midrst no_header bit_count", 64'(bit_count), 64'(0));
        check("midrst no_header pulses", 64'(hf_cnt), 64'(0));
        send_hdr(HDR);
        build_seq(7'b0110110, 20);
        send_fill("midrst_relock");
        send_check(20);
        check("midrst relock locked", 64'(locked), 64'(1));
        check("midrst relock bit_count", 64'(bit_count), 64'(20));
        check("midrst relock err_count", 64'(err_count), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
